// File: rtl/addertree_pkg.sv
// Shared definitions for the pipelined adder tree / accumulator.
//   clog_radix : number of RADIX-ary levels needed to reduce n operands to one
//   sum_width  : exact width of the full tree sum
//   side_t     : sideband carried beside the data in every pipeline stage
package addertree_pkg;

   // valid marks a real beat, last is the effective group-last flag
   typedef struct packed {
      logic valid;
      logic last;
   } side_t;

   function automatic int clog_radix(input int n, input int r);
      int     lv;
      longint p;
      lv = 32'sd0;
      p  = 64'sd1;
      for (int i = 32'sd0; i < 32'sd32; i++) begin
         if (p < longint'(n)) begin
            p  = p * longint'(r);
            lv = lv + 32'sd1;
         end else begin
            p  = p;
         end
      end
      return lv;
   endfunction

   function automatic int sum_width(input int n_in, input int in_w);
      return in_w + $clog2(n_in);
   endfunction

endpackage

// File: rtl/addertree_level.sv
// One registered RADIX-ary reduction level of the adder tree.
//   clk, rst        : clock, async active-high reset
//   en              : pipeline advance enable
//   in_side/in_data : N_IN_L values of width W plus sideband
//   out_side/out_data : N_IN_L/RADIX registered partial sums plus sideband
// N_IN_L must be a multiple of RADIX; the top pads the operand vector so
// this always holds. Widths are sized so that no partial sum can overflow,
// so plain modular addition gives the exact two's-complement result.
module addertree_level
   import addertree_pkg::*;
#(
   parameter int N_IN_L = 32'sd9,
   parameter int W      = 32'sd20,
   parameter int RADIX  = 32'sd3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  side_t                            in_side,
   input  logic [N_IN_L-1:0][W-1:0]         in_data,
   output side_t                            out_side,
   output logic [N_IN_L/RADIX-1:0][W-1:0]   out_data
);

   localparam int N_OUT = N_IN_L / RADIX;

   logic [N_OUT-1:0][W-1:0] sum_s;

   // group-of-RADIX adders feeding the stage register
   always_comb begin
      sum_s = '0;
      for (int o = 32'sd0; o < N_OUT; o++) begin
         for (int k = 32'sd0; k < RADIX; k++) begin
            sum_s[o] = sum_s[o] + in_data[o*RADIX + k];
         end
      end
   end

   // stage register: data and sideband advance together on en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_side <= '0;
         out_data <= '0;
      end else if (en) begin
         out_side <= in_side;
         out_data <= sum_s;
      end
   end

endmodule

// File: rtl/addertree_acc_pipe.sv
// Pipelined signed adder tree with valid/ready handshake and an optional
// multi-beat saturating accumulator.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input beat handshake (in_ready is combinational)
//   in_data             : N_IN signed IN_W-bit operands
//   in_last             : final beat of an accumulation group
//   acc_en              : 1 = accumulate until in_last, 0 = every beat closes
//   out_valid/out_ready : result handshake
//   out_data            : saturated group sum, ACC_W bits signed
//   out_sat             : group clamped at least once
module addertree_acc_pipe
   import addertree_pkg::*;
#(
   parameter int N_IN  = 32'sd9,
   parameter int IN_W  = 32'sd16,
   parameter int RADIX = 32'sd3,
   parameter int ACC_W = 32'sd24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N_IN-1:0][IN_W-1:0]    in_data,
   input  logic                         in_last,
   input  logic                         acc_en,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_W-1:0]      out_data,
   output logic                         out_sat
);

   localparam int SUM_W  = sum_width(N_IN, IN_W);
   localparam int LEVELS = clog_radix(N_IN, RADIX);
   localparam int N_PAD  = RADIX ** LEVELS;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic                        en_s;
   logic [N_PAD-1:0][SUM_W-1:0] pad_s;
   side_t                       side0_s;
   logic [SUM_W-1:0]            tree_sum_s;
   side_t                       tree_side_s;

   logic [ACC_W:0]              base_s;
   logic [ACC_W:0]              wide_s;
   logic [ACC_W-1:0]            clamp_s;
   logic                        ovf_s;
   logic                        sat_grp_s;

   logic [ACC_W-1:0]            acc_r;
   logic                        sat_r;
   logic                        first_r;
   logic                        out_valid_r;
   logic [ACC_W-1:0]            out_data_r;
   logic                        out_sat_r;

   // the whole pipeline freezes only while a result waits to be consumed
   assign en_s     = !out_valid_r || out_ready;
   assign in_ready = en_s;

   // sign-extend operands to the exact sum width; padding lanes stay zero
   always_comb begin
      pad_s = '0;
      for (int i = 32'sd0; i < N_IN; i++) begin
         pad_s[i] = {{(SUM_W-IN_W){in_data[i][IN_W-1]}}, in_data[i]};
      end
   end

   // effective last is captured at acceptance so later acc_en edges cannot
   // reinterpret a beat already in flight
   always_comb begin
      side0_s.valid = in_valid && en_s;
      side0_s.last  = in_last || !acc_en;
   end

   for (genvar l = 32'sd0; l < LEVELS; l++) begin : g_lvl
      localparam int NI = N_PAD / (RADIX ** l);
      logic [NI/RADIX-1:0][SUM_W-1:0] dat_s;
      side_t                          side_s;
      if (l == 32'sd0) begin : g_first
         addertree_level #(
            .N_IN_L (NI),
            .W      (SUM_W),
            .RADIX  (RADIX)
         ) u_level (
            .clk      (clk),
            .rst      (rst),
            .en       (en_s),
            .in_side  (side0_s),
            .in_data  (pad_s),
            .out_side (side_s),
            .out_data (dat_s)
         );
      end else begin : g_next
         addertree_level #(
            .N_IN_L (NI),
            .W      (SUM_W),
            .RADIX  (RADIX)
         ) u_level (
            .clk      (clk),
            .rst      (rst),
            .en       (en_s),
            .in_side  (g_lvl[l-1].side_s),
            .in_data  (g_lvl[l-1].dat_s),
            .out_side (side_s),
            .out_data (dat_s)
         );
      end
   end

   assign tree_sum_s  = g_lvl[LEVELS-1].dat_s[0];
   assign tree_side_s = g_lvl[LEVELS-1].side_s;

   // accumulate at ACC_W+1 bits; the two top bits disagree exactly when the
   // sum left the ACC_W range, and the top bit then gives the direction
   always_comb begin
      base_s    = first_r ? {(ACC_W+1){1'b0}} : {acc_r[ACC_W-1], acc_r};
      wide_s    = base_s + {{(ACC_W+1-SUM_W){tree_sum_s[SUM_W-1]}}, tree_sum_s};
      if (wide_s[ACC_W] != wide_s[ACC_W-1]) begin
         clamp_s = wide_s[ACC_W] ? ACC_MIN : ACC_MAX;
         ovf_s   = 1'b1;
      end else begin
         clamp_s = wide_s[ACC_W-1:0];
         ovf_s   = 1'b0;
      end
      sat_grp_s = (first_r ? 1'b0 : sat_r) | ovf_s;
   end

   // accumulator, group state and output register; bubbles leave acc alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r       <= '0;
         sat_r       <= 1'b0;
         first_r     <= 1'b1;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_sat_r   <= 1'b0;
      end else if (en_s) begin
         out_valid_r <= tree_side_s.valid && tree_side_s.last;
         if (tree_side_s.valid) begin
            if (tree_side_s.last) begin
               out_data_r <= clamp_s;
               out_sat_r  <= sat_grp_s;
               acc_r      <= '0;
               sat_r      <= 1'b0;
               first_r    <= 1'b1;
            end else begin
               acc_r      <= clamp_s;
               sat_r      <= sat_grp_s;
               first_r    <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_sat   = out_sat_r;

endmodule
